// File: rtl/reg_rename_file_pkg.sv
// Shared processor defines: default widths and index helpers used by the rename file,
// the ROB and the instruction queue.
package reg_rename_file_pkg;

   localparam int unsigned DefXlen = 32;
   localparam int unsigned DefNreg = 32;
   localparam int unsigned DefRobW = 4;
   localparam int unsigned DefNrp  = 2;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned DefRidx = idx_width(DefNreg);

   typedef logic [DefXlen-1:0] xlen_t;
   typedef logic [DefRobW-1:0] rob_tag_t;
   typedef logic [DefRidx-1:0] reg_idx_t;

endpackage

// File: rtl/reg_rename_file_if.sv
// Rename-file bus: operand read ports, dispatch rename, commit writeback and busy count.
interface reg_rename_file_if
   import reg_rename_file_pkg::*;
#(
   parameter int unsigned XLEN  = DefXlen,
   parameter int unsigned NREG  = DefNreg,
   parameter int unsigned ROB_W = DefRobW,
   parameter int unsigned NRP   = DefNrp
);
   localparam int unsigned RIDX = idx_width(NREG);
   localparam int unsigned CW   = $clog2(NREG + 1);

   logic                  rdy;
   logic                  flush_i;
   logic [NRP*RIDX-1:0]   rs_idx_i;
   logic [NRP-1:0]        rs_busy_o;
   logic [NRP*ROB_W-1:0]  rs_tag_o;
   logic [NRP*XLEN-1:0]   rs_val_o;
   logic                  disp_valid_i;
   logic [RIDX-1:0]       disp_rd_i;
   logic [ROB_W-1:0]      disp_tag_i;
   logic                  cmt_valid_i;
   logic [RIDX-1:0]       cmt_rd_i;
   logic [ROB_W-1:0]      cmt_tag_i;
   logic [XLEN-1:0]       cmt_val_i;
   logic [CW-1:0]         busy_cnt_o;

   modport master (
      output rdy, flush_i, rs_idx_i, disp_valid_i, disp_rd_i, disp_tag_i,
             cmt_valid_i, cmt_rd_i, cmt_tag_i, cmt_val_i,
      input  rs_busy_o, rs_tag_o, rs_val_o, busy_cnt_o
   );

   modport slave (
      input  rdy, flush_i, rs_idx_i, disp_valid_i, disp_rd_i, disp_tag_i,
             cmt_valid_i, cmt_rd_i, cmt_tag_i, cmt_val_i,
      output rs_busy_o, rs_tag_o, rs_val_o, busy_cnt_o
   );

endinterface

// File: rtl/rrf_read_port.sv
// One combinational operand read port with same-cycle commit bypass.
module rrf_read_port
   import reg_rename_file_pkg::*;
#(
   parameter int unsigned XLEN  = DefXlen,
   parameter int unsigned NREG  = DefNreg,
   parameter int unsigned ROB_W = DefRobW,
   localparam int unsigned RIDX = idx_width(NREG)
) (
   input  logic [RIDX-1:0]  idx,
   input  logic [NREG-1:0]  busy,
   input  logic [ROB_W-1:0] tag   [NREG],
   input  logic [XLEN-1:0]  value [NREG],
   input  logic             cmt_en,
   input  logic [RIDX-1:0]  cmt_rd,
   input  logic [ROB_W-1:0] cmt_tag,
   input  logic [XLEN-1:0]  cmt_val,
   output logic             rd_busy,
   output logic [ROB_W-1:0] rd_tag,
   output logic [XLEN-1:0]  rd_val
);

   logic             st_busy;
   logic [ROB_W-1:0] st_tag;
   logic [XLEN-1:0]  st_val;
   logic             hit;

   always_comb begin
      st_busy = 1'b0;
      st_tag  = '0;
      st_val  = '0;
      // x0 and out-of-range indices read as a constant zero register
      if (idx != '0 && 32'(idx) < NREG) begin
         st_busy = busy[idx];
         st_tag  = tag[idx];
         st_val  = value[idx];
      end
      hit     = st_busy && cmt_en && (cmt_rd == idx) && (cmt_tag == st_tag);
      rd_busy = st_busy && !hit;
      rd_tag  = st_tag;
      rd_val  = hit ? cmt_val : st_val;
   end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with rename state (busy bit + producer ROB tag per register).
module reg_rename_file
   import reg_rename_file_pkg::*;
#(
   parameter int unsigned XLEN  = DefXlen,
   parameter int unsigned NREG  = DefNreg,
   parameter int unsigned ROB_W = DefRobW,
   parameter int unsigned NRP   = DefNrp
) (
   input logic              clk,
   input logic              rst,
   reg_rename_file_if.slave bus
);
   localparam int unsigned RIDX = idx_width(NREG);
   localparam int unsigned CW   = $clog2(NREG + 1);

   logic [XLEN-1:0]  value_q [NREG];
   logic [XLEN-1:0]  value_d [NREG];
   logic [ROB_W-1:0] tag_q   [NREG];
   logic [ROB_W-1:0] tag_d   [NREG];
   logic [NREG-1:0]  busy_q, busy_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   always_comb begin
      value_d = value_q;
      tag_d   = tag_q;
      busy_d  = busy_q;
      if (bus.rdy) begin
         // Entry 0 is never written; out-of-range indices match no entry.
         for (int unsigned r = 1; r < NREG; r++) begin
            if (bus.cmt_valid_i && bus.cmt_rd_i == RIDX'(r)) begin
               value_d[r] = bus.cmt_val_i;
               if (tag_q[r] == bus.cmt_tag_i) busy_d[r] = 1'b0;
            end
            // Dispatch rename is applied after commit so it wins on the same rd
            if (bus.flush_i) begin
               busy_d[r] = 1'b0;
            end else if (bus.disp_valid_i && bus.disp_rd_i == RIDX'(r)) begin
               busy_d[r] = 1'b1;
               tag_d[r]  = bus.disp_tag_i;
            end
         end
      end
      cnt_d = '0;
      for (int unsigned r = 0; r < NREG; r++) cnt_d = cnt_d + CW'(busy_d[r]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         value_q <= '{default: '0};
         tag_q   <= '{default: '0};
         busy_q  <= '0;
         cnt_q   <= '0;
      end else begin
         value_q <= value_d;
         tag_q   <= tag_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.busy_cnt_o = cnt_q;

   for (genvar p = 0; p < NRP; p++) begin : g_port
      rrf_read_port #(
         .XLEN  (XLEN),
         .NREG  (NREG),
         .ROB_W (ROB_W)
      ) u_port (
         .idx     (bus.rs_idx_i[p*RIDX +: RIDX]),
         .busy    (busy_q),
         .tag     (tag_q),
         .value   (value_q),
         .cmt_en  (bus.rdy && bus.cmt_valid_i),
         .cmt_rd  (bus.cmt_rd_i),
         .cmt_tag (bus.cmt_tag_i),
         .cmt_val (bus.cmt_val_i),
         .rd_busy (bus.rs_busy_o[p]),
         .rd_tag  (bus.rs_tag_o[p*ROB_W +: ROB_W]),
         .rd_val  (bus.rs_val_o[p*XLEN +: XLEN])
      );
   end

endmodule

// File: tb/tb_reg_rename_file.sv
// Bench for reg_rename_file: directed scenarios then random traffic against an array model.
module tb_reg_rename_file;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREG  = 32;
   localparam int unsigned ROB_W = 4;
   localparam int unsigned NRP   = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   reg_rename_file_if #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .NRP(NRP)) bus ();

   reg_rename_file #(.XLEN(XLEN), .NREG(NREG), .ROB_W(ROB_W), .NRP(NRP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;
   bit model_valid = 1'b0;

   logic [XLEN-1:0]  m_val  [NREG];
   bit               m_busy [NREG];
   logic [ROB_W-1:0] m_tag  [NREG];
   int               m_cnt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.rdy = 1'b1;  bus.flush_i = 1'b0;
      bus.disp_valid_i = 1'b0; bus.disp_rd_i = '0; bus.disp_tag_i = '0;
      bus.cmt_valid_i = 1'b0;  bus.cmt_rd_i = '0;  bus.cmt_tag_i = '0; bus.cmt_val_i = '0;
   endtask

   task automatic set_rd(input int a, input int b);
      bus.rs_idx_i = {5'(b), 5'(a)};
   endtask

   task automatic disp(input int rd, input int t);
      bus.disp_valid_i = 1'b1; bus.disp_rd_i = 5'(rd); bus.disp_tag_i = 4'(t);
   endtask

   task automatic cmt(input int rd, input int t, input logic [XLEN-1:0] v);
      bus.cmt_valid_i = 1'b1; bus.cmt_rd_i = 5'(rd); bus.cmt_tag_i = 4'(t); bus.cmt_val_i = v;
   endtask

   // Expected read of register i under the current inputs, before the edge.
   task automatic exp_read(input int i, output bit eb, output logic [ROB_W-1:0] et,
                           output logic [XLEN-1:0] ev);
      eb = 0; et = '0; ev = '0;
      if (i != 0 && i < NREG) begin
         eb = m_busy[i]; et = m_tag[i]; ev = m_val[i];
         if (eb && bus.rdy && bus.cmt_valid_i && int'(bus.cmt_rd_i) == i
             && bus.cmt_tag_i == m_tag[i]) begin
            eb = 0; ev = bus.cmt_val_i;
         end
      end
   endtask

   task automatic model_edge();
      int cr, dr;
      cr = int'(bus.cmt_rd_i);
      dr = int'(bus.disp_rd_i);
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin m_val[i] = '0; m_busy[i] = 0; m_tag[i] = '0; end
      end else if (bus.rdy) begin
         if (bus.cmt_valid_i && cr != 0 && cr < NREG) begin
            m_val[cr] = bus.cmt_val_i;
            if (m_tag[cr] == bus.cmt_tag_i) m_busy[cr] = 0;
         end
         if (bus.flush_i) begin
            for (int i = 0; i < NREG; i++) m_busy[i] = 0;
         end else if (bus.disp_valid_i && dr != 0 && dr < NREG) begin
            m_busy[dr] = 1; m_tag[dr] = bus.disp_tag_i;
         end
      end
      m_cnt = 0;
      for (int i = 0; i < NREG; i++) m_cnt += int'(m_busy[i]);
   endtask

   task automatic step();
      bit eb;
      logic [ROB_W-1:0] et;
      logic [XLEN-1:0] ev;
      #2;
      if (model_valid) begin
         for (int p = 0; p < NRP; p++) begin
            exp_read(int'(bus.rs_idx_i[p*5 +: 5]), eb, et, ev);
            chk($sformatf("m_busy%0d", p), 64'(bus.rs_busy_o[p]), 64'(eb));
            if (eb) chk($sformatf("m_tag%0d", p), 64'(bus.rs_tag_o[p*ROB_W +: ROB_W]), 64'(et));
            else    chk($sformatf("m_val%0d", p), 64'(bus.rs_val_o[p*XLEN +: XLEN]), 64'(ev));
         end
      end
      @(posedge clk);
      model_edge();
      if (rst) model_valid = 1'b1;
      #1;
      if (model_valid) chk("m_cnt", 64'(bus.busy_cnt_o), 64'(m_cnt));
   endtask

   initial begin
      int r;
      rst = 1'b1;
      idle();
      set_rd(0, 0);
      step(); step();
      rst = 1'b0;

      // Reset state
      set_rd(5, 5); #1;
      chk("rst_busy0", 64'(bus.rs_busy_o[0]), 64'd0);
      chk("rst_val0", 64'(bus.rs_val_o[31:0]), 64'd0);
      chk("rst_val1", 64'(bus.rs_val_o[63:32]), 64'd0);
      chk("rst_cnt", 64'(bus.busy_cnt_o), 64'd0);

      // Rename then commit with bypass
      disp(5, 3); step(); idle(); set_rd(5, 5); #1;
      chk("x5_busy", 64'(bus.rs_busy_o[0]), 64'd1);
      chk("x5_tag", 64'(bus.rs_tag_o[3:0]), 64'd3);
      chk("x5_cnt", 64'(bus.busy_cnt_o), 64'd1);
      cmt(5, 3, 32'hDEAD); #1;
      chk("x5_byp_busy", 64'(bus.rs_busy_o[0]), 64'd0);
      chk("x5_byp_val", 64'(bus.rs_val_o[31:0]), 64'hDEAD);
      step(); idle(); set_rd(5, 0); #1;
      chk("x5_done_busy", 64'(bus.rs_busy_o[0]), 64'd0);
      chk("x5_done_val", 64'(bus.rs_val_o[31:0]), 64'hDEAD);
      chk("x5_done_cnt", 64'(bus.busy_cnt_o), 64'd0);

      // Stale-tag commit leaves the newer rename in place
      disp(7, 2); step(); disp(7, 6); step(); idle(); cmt(7, 2, 32'h11); step();
      idle(); set_rd(7, 7); #1;
      chk("x7_busy", 64'(bus.rs_busy_o[0]), 64'd1);
      chk("x7_tag", 64'(bus.rs_tag_o[3:0]), 64'd6);

      // Same-cycle dispatch and matching commit on one rd
      disp(9, 1); step(); idle(); disp(9, 4); cmt(9, 1, 32'h22); step();
      idle(); set_rd(9, 9); #1;
      chk("x9_busy", 64'(bus.rs_busy_o[0]), 64'd1);
      chk("x9_tag", 64'(bus.rs_tag_o[3:0]), 64'd4);
      chk("x9_cnt", 64'(bus.busy_cnt_o), 64'd2);

      // Flush with a same-cycle commit write
      disp(3, 5); step(); idle();
      chk("pre_flush_cnt", 64'(bus.busy_cnt_o), 64'd3);
      bus.flush_i = 1'b1; disp(12, 7); cmt(3, 0, 32'h33); step();
      idle(); set_rd(3, 7); #1;
      chk("x3_busy", 64'(bus.rs_busy_o[0]), 64'd0);
      chk("x3_val", 64'(bus.rs_val_o[31:0]), 64'h33);
      chk("x7_val", 64'(bus.rs_val_o[63:32]), 64'h11);
      chk("flush_cnt", 64'(bus.busy_cnt_o), 64'd0);

      // x0 writes and rdy-low writes are dropped
      disp(0, 1); cmt(0, 0, 32'h44); step();
      idle(); bus.rdy = 1'b0; disp(4, 2); cmt(4, 0, 32'h55); step();
      idle(); set_rd(0, 4); #1;
      chk("x0_busy", 64'(bus.rs_busy_o[0]), 64'd0);
      chk("x0_val", 64'(bus.rs_val_o[31:0]), 64'd0);
      chk("x4_busy", 64'(bus.rs_busy_o[1]), 64'd0);
      chk("x4_val", 64'(bus.rs_val_o[63:32]), 64'd0);
      chk("x4_cnt", 64'(bus.busy_cnt_o), 64'd0);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 149) == 0);
         bus.rdy = ($urandom_range(0, 7) != 0);
         bus.flush_i = ($urandom_range(0, 29) == 0);
         bus.disp_valid_i = $urandom_range(0, 1) == 1;
         bus.disp_rd_i = 5'($urandom);
         bus.disp_tag_i = 4'($urandom);
         bus.cmt_valid_i = $urandom_range(0, 1) == 1;
         r = int'($urandom_range(0, NREG - 1));
         bus.cmt_rd_i = 5'(r);
         bus.cmt_tag_i = ($urandom_range(0, 2) != 0) ? m_tag[r] : 4'($urandom);
         bus.cmt_val_i = $urandom;
         set_rd(int'($urandom_range(0, NREG - 1)),
                ($urandom_range(0, 1) == 1) ? r : int'($urandom_range(0, NREG - 1)));
         step();
      end
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reg_rename_file.md
REG_RENAME_FILE -- requirements
Module: reg_rename_file

Interface
REQ-001 Parameter XLEN, default 32, architectural register data width.
REQ-002 Parameter NREG, default 32, register count; RIDX = clog2(NREG).
REQ-003 Parameter ROB_W, default 4, ROB tag width.
REQ-004 Parameter NRP, default 2, number of operand read ports.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 rdy  in  1  global enable; low freezes all state.
REQ-008 flush_i  in  1  mispredict recovery; clears all rename state.
REQ-009 rs_idx_i  in  NRP*RIDX  packed source register indices.
REQ-010 rs_busy_o  out  NRP  source awaits an in-flight producer.
REQ-011 rs_tag_o  out  NRP*ROB_W  producer ROB tag, valid when busy.
REQ-012 rs_val_o  out  NRP*XLEN  operand value, valid when not busy.
REQ-013 disp_valid_i  in  1  dispatch renames a destination this cycle.
REQ-014 disp_rd_i  in  RIDX  dispatch destination index.
REQ-015 disp_tag_i  in  ROB_W  ROB tag allocated to the dispatch.
REQ-016 cmt_valid_i  in  1  ROB commits a register write this cycle.
REQ-017 cmt_rd_i  in  RIDX  commit destination index.
REQ-018 cmt_tag_i  in  ROB_W  ROB tag of the committing entry.
REQ-019 cmt_val_i  in  XLEN  committed value.
REQ-020 busy_cnt_o  out  clog2(NREG+1)  registered count of busy registers.

Function
REQ-021 State: value[NREG], busy[NREG], tag[NREG]; register 0 reads value 0, busy 0, tag 0, and ignores all writes.
REQ-022 Read ports are combinational. Each port returns the stored busy, tag and value, subject to REQ-023.
REQ-023 Commit bypass: a port reporting busy with tag equal to cmt_tag_i, while cmt_valid_i and cmt_rd_i equal the port index, returns busy 0 and value cmt_val_i in the same cycle.
REQ-024 Reads see pre-edge rename state. A dispatch reading its own rd receives the old mapping.
REQ-025 Commit, when rdy is high and rd is not 0: value[rd] <= cmt_val_i. busy[rd] <= 0 only if tag[rd] == cmt_tag_i; a stale tag leaves busy set.
REQ-026 Dispatch, when rdy is high, flush_i is low and rd is not 0: busy[rd] <= 1, tag[rd] <= disp_tag_i.
REQ-027 When dispatch and commit target the same rd in one cycle, the dispatch rename wins and the commit value is still written.
REQ-028 Flush: every busy <= 0 and dispatch is ignored. A same-cycle commit value write still occurs.
REQ-029 busy_cnt_o equals the number of set busy bits after each edge: +1 on a dispatch to a non-busy reg, -1 on a tag-matching clear, net 0 on simultaneous set and clear, 0 after flush.
REQ-030 When rdy is low, all inputs except rst are ignored and state holds. Outputs remain combinational on held state.
REQ-031 Out-of-range indices (>= NREG) read as register 0 and write nothing.

Reset
REQ-032 On rst, all value, busy and tag entries clear to 0 and busy_cnt_o = 0. rst overrides rdy, flush_i, dispatch and commit.
REQ-033 Reset mid-operation discards all renames with no residual busy bits.

Structure
REQ-034 Parameter defaults, RIDX and the tag/data width macros belong in the shared processor defines package used by the ROB and instruction queue.
REQ-035 One sub-module, rrf_read_port (one read port with its bypass), is instantiated NRP times. All storage stays in the top module.

Verification
REQ-036 Reset, then read x5 on both ports -> busy 0, value 0, busy_cnt_o 0.
REQ-037 Dispatch rd=5 tag=3; next cycle read x5 -> busy 1, tag 3, busy_cnt_o 1. Commit rd=5 tag=3 val=0xDEAD in the same cycle -> port shows busy 0, value 0xDEAD; next cycle stored busy 0, busy_cnt_o 0.
REQ-038 Dispatch rd=7 tag=2, then rd=7 tag=6, then commit rd=7 tag=2 val=0x11 -> x7 stays busy with tag 6, value 0x11.
REQ-039 Same cycle dispatch rd=9 tag=4 and commit rd=9 (matching old tag 1) val=0x22 -> x9 busy tag 4, value 0x22.
REQ-040 Three registers busy, flush_i with commit rd=3 val=0x33 -> all busy 0, x3 = 0x33, busy_cnt_o 0.
REQ-041 Dispatch and commit to rd=0, and rdy low with dispatch rd=4 -> x0 stays 0, not busy; x4 unchanged.
